i2c_cmos_cfg_sequencer: RTL and testbench

//  Walks a sensor register-configuration LUT (index -> {reg_addr, reg_data}) and drives an I2C master core, one LUT entry per transaction.

---
 rtl/cmos_cfg_pkg.sv | 22 ++
 rtl/cfg_delay_timer.sv | 40 ++++
 rtl/i2c_cmos_cfg_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_i2c_cmos_cfg_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cmos_cfg_pkg.sv
// Shared types and constants for the CMOS sensor I2C configuration sequencer.
package cmos_cfg_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP = 3'd0,
        ST_FETCH = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DELAY = 3'd5,
        ST_DONE  = 3'd6,
        ST_FAIL  = 3'd7
    } cfg_state_t;

    localparam int DEFAULT_DELAY_CYCLES   = 1000000;
    localparam int DEFAULT_POWERUP_CYCLES = 1000000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cfg_delay_timer.sv
// Down-counter shared by the power-up wait and the post-soft-reset settle delay.
// Comes out of reset already running with RESET_COUNT; expire is high on the last counted cycle.
module cfg_delay_timer #(
    parameter int CNT_W       = 21,
    parameter int RESET_COUNT = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic             expire
);

    logic [CNT_W-1:0] cnt_r;
    logic             running_r;

    assign expire = running_r && (cnt_r <= CNT_W'(1));

    // Count register: reset starts the power-up count, load starts a new delay
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= CNT_W'(RESET_COUNT);
            running_r <= 1'b1;
        end else if (clear) begin
            cnt_r     <= {CNT_W{1'b0}};
            running_r <= 1'b0;
        end else if (load) begin
            cnt_r     <= load_value;
            running_r <= 1'b1;
        end else if (running_r) begin
            cnt_r     <= (cnt_r == {CNT_W{1'b0}}) ? cnt_r : cnt_r - CNT_W'(1);
            running_r <= !expire;
        end else begin
            cnt_r     <= cnt_r;
            running_r <= 1'b0;
        end
    end

endmodule

// File: rtl/i2c_cmos_cfg_sequencer.sv
// Walks the sensor register LUT and drives the I2C master one entry per transaction,
// with ID-read verification, NACK retry, settle delay after soft reset, and restart.
module i2c_cmos_cfg_sequencer
    import cmos_cfg_pkg::*;
#(
    parameter int REG_ADDR_W     = 8,
    parameter int REG_DATA_W     = 8,
    parameter int INDEX_W        = 8,
    parameter int READ_ENTRIES   = 2,
    parameter int DELAY_INDEX    = 2,
    parameter int DELAY_CYCLES   = DEFAULT_DELAY_CYCLES,
    parameter int POWERUP_CYCLES = DEFAULT_POWERUP_CYCLES,
    parameter int MAX_RETRY      = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cfg_restart,
    output logic [INDEX_W-1:0]               lut_index,
    input  logic [REG_ADDR_W+REG_DATA_W-1:0] lut_data,
    input  logic [INDEX_W-1:0]               lut_size,
    output logic                             i2c_req,
    output logic                             i2c_rd,
    output logic [REG_ADDR_W-1:0]            i2c_addr,
    output logic [REG_DATA_W-1:0]            i2c_wdata,
    input  logic                             i2c_done,
    input  logic                             i2c_nack,
    input  logic [REG_DATA_W-1:0]            i2c_rdata,
    output logic                             cfg_busy,
    output logic                             cfg_done,
    output logic                             cfg_error,
    output logic                             id_mismatch
);

    localparam int CNT_W   = $clog2(max_int(DELAY_CYCLES, POWERUP_CYCLES) + 1);
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    cfg_state_t              state_r, state_s;
    logic [INDEX_W-1:0]      lut_index_r, index_s;
    logic [RETRY_W-1:0]      retry_r, retry_s;
    logic [REG_ADDR_W-1:0]   i2c_addr_r, addr_s;
    logic [REG_DATA_W-1:0]   i2c_wdata_r, wdata_s;
    logic                    i2c_rd_r, rd_s;
    logic                    i2c_req_r, cfg_busy_r, cfg_done_r, cfg_error_r;
    logic                    id_mismatch_r, mismatch_s;
    logic                    restart_pend_r, pend_s;
    logic                    restart_s, last_entry_s, delay_entry_s;
    logic                    timer_load_s, timer_clear_s, timer_expire_s;

    assign lut_index   = lut_index_r;
    assign i2c_req     = i2c_req_r;
    assign i2c_rd      = i2c_rd_r;
    assign i2c_addr    = i2c_addr_r;
    assign i2c_wdata   = i2c_wdata_r;
    assign cfg_busy    = cfg_busy_r;
    assign cfg_done    = cfg_done_r;
    assign cfg_error   = cfg_error_r;
    assign id_mismatch = id_mismatch_r;

    // One bit wider than the index so lut_size = 2^INDEX_W-1 still terminates
    assign last_entry_s  = ({1'b0, lut_index_r} + {{INDEX_W{1'b0}}, 1'b1}) >= {1'b0, lut_size};
    assign delay_entry_s = (lut_index_r == INDEX_W'(DELAY_INDEX)) && !i2c_rd_r;
    // A restart seen during WAIT is deferred until the master reports completion
    assign restart_s     = (state_r == ST_WAIT) ? (i2c_done && (restart_pend_r || cfg_restart))
                                                : cfg_restart;

    cfg_delay_timer #(
        .CNT_W       (CNT_W),
        .RESET_COUNT (POWERUP_CYCLES)
    ) u_delay_timer (
        .clk        (clk),
        .rst        (rst),
        .clear      (timer_clear_s),
        .load       (timer_load_s),
        .load_value (CNT_W'(DELAY_CYCLES)),
        .expire     (timer_expire_s)
    );

    // Next-state and next-datapath decode
    always_comb begin
        state_s       = state_r;
        index_s       = lut_index_r;
        retry_s       = retry_r;
        mismatch_s    = id_mismatch_r;
        pend_s        = restart_pend_r;
        addr_s        = i2c_addr_r;
        wdata_s       = i2c_wdata_r;
        rd_s          = i2c_rd_r;
        timer_load_s  = 1'b0;
        timer_clear_s = 1'b0;
        if (restart_s) begin
            state_s       = ST_FETCH;
            index_s       = {INDEX_W{1'b0}};
            retry_s       = {RETRY_W{1'b0}};
            mismatch_s    = 1'b0;
            pend_s        = 1'b0;
            timer_clear_s = 1'b1;
        end else begin
            case (state_r)
                ST_PWRUP: begin
                    if (timer_expire_s) begin
                        state_s = (lut_size == {INDEX_W{1'b0}}) ? ST_DONE : ST_FETCH;
                    end else begin
                        state_s = ST_PWRUP;
                    end
                end
                ST_FETCH: begin
                    addr_s  = lut_data[REG_ADDR_W+REG_DATA_W-1 -: REG_ADDR_W];
                    wdata_s = lut_data[REG_DATA_W-1:0];
                    rd_s    = {1'b0, lut_index_r} < (INDEX_W+1)'(READ_ENTRIES);
                    state_s = (lut_size == {INDEX_W{1'b0}}) ? ST_DONE : ST_ISSUE;
                end
                ST_ISSUE: begin
                    state_s = ST_WAIT;
                end
                ST_WAIT: begin
                    pend_s = restart_pend_r | cfg_restart;
                    if (!i2c_done) begin
                        state_s = ST_WAIT;
                    end else if (i2c_nack) begin
                        if (retry_r < RETRY_W'(MAX_RETRY)) begin
                            retry_s = retry_r + RETRY_W'(1);
                            state_s = ST_ISSUE;
                        end else begin
                            state_s = ST_FAIL;
                        end
                    end else begin
                        retry_s = {RETRY_W{1'b0}};
                        if (i2c_rd_r && (i2c_rdata != i2c_wdata_r)) begin
                            mismatch_s = 1'b1;
                        end else begin
                            mismatch_s = id_mismatch_r;
                        end
                        state_s = ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (delay_entry_s) begin
                        timer_load_s = 1'b1;
                        state_s      = ST_DELAY;
                    end else if (last_entry_s) begin
                        state_s = ST_DONE;
                    end else begin
                        index_s = lut_index_r + INDEX_W'(1);
                        state_s = ST_FETCH;
                    end
                end
                ST_DELAY: begin
                    if (!timer_expire_s) begin
                        state_s = ST_DELAY;
                    end else if (last_entry_s) begin
                        state_s = ST_DONE;
                    end else begin
                        index_s = lut_index_r + INDEX_W'(1);
                        state_s = ST_FETCH;
                    end
                end
                ST_DONE: state_s = ST_DONE;
                ST_FAIL: state_s = ST_FAIL;
                default: state_s = ST_PWRUP;
            endcase
        end
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_PWRUP;
            lut_index_r    <= {INDEX_W{1'b0}};
            retry_r        <= {RETRY_W{1'b0}};
            i2c_addr_r     <= {REG_ADDR_W{1'b0}};
            i2c_wdata_r    <= {REG_DATA_W{1'b0}};
            i2c_rd_r       <= 1'b0;
            i2c_req_r      <= 1'b0;
            cfg_busy_r     <= 1'b0;
            cfg_done_r     <= 1'b0;
            cfg_error_r    <= 1'b0;
            id_mismatch_r  <= 1'b0;
            restart_pend_r <= 1'b0;
        end else begin
            state_r        <= state_s;
            lut_index_r    <= index_s;
            retry_r        <= retry_s;
            i2c_addr_r     <= addr_s;
            i2c_wdata_r    <= wdata_s;
            i2c_rd_r       <= rd_s;
            i2c_req_r      <= (state_s == ST_ISSUE);
            cfg_busy_r     <= (state_s != ST_DONE) && (state_s != ST_FAIL);
            cfg_done_r     <= (state_s == ST_DONE);
            cfg_error_r    <= (state_s == ST_FAIL);
            id_mismatch_r  <= mismatch_s;
            restart_pend_r <= pend_s;
        end
    end

endmodule

// File: tb/tb_i2c_cmos_cfg_sequencer.sv
// Directed bench: behavioural I2C master plus a linear stimulus sequence with immediate assertions.
module tb_i2c_cmos_cfg_sequencer;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_restart;
    logic [7:0]  lut_index;
    logic [15:0] lut_data;
    logic [7:0]  lut_size;
    logic        i2c_req, i2c_rd;
    logic [7:0]  i2c_addr, i2c_wdata;
    logic        i2c_done, i2c_nack;
    logic [7:0]  i2c_rdata;
    logic        cfg_busy, cfg_done, cfg_error, id_mismatch;

    logic [15:0] lut_tab [0:7];
    int          cyc = 0;
    int          req_n = 0;
    int          req_idx [0:127];
    logic        req_rd [0:127];
    logic [7:0]  req_addr [0:127];
    logic [7:0]  req_wdata [0:127];
    int          req_cyc [0:127];
    int          done_cyc [0:127];
    int          nack_idx;
    int          nack_end;
    int          nack_given = 0;
    logic        id_bad;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb lut_data = (lut_index < 8'd5) ? lut_tab[lut_index[2:0]] : 16'h0000;

    i2c_cmos_cfg_sequencer #(
        .REG_ADDR_W(8), .REG_DATA_W(8), .INDEX_W(8), .READ_ENTRIES(2), .DELAY_INDEX(2),
        .DELAY_CYCLES(10), .POWERUP_CYCLES(10), .MAX_RETRY(3)
    ) dut (
        .clk(clk), .rst(rst), .cfg_restart(cfg_restart), .lut_index(lut_index),
        .lut_data(lut_data), .lut_size(lut_size), .i2c_req(i2c_req), .i2c_rd(i2c_rd),
        .i2c_addr(i2c_addr), .i2c_wdata(i2c_wdata), .i2c_done(i2c_done), .i2c_nack(i2c_nack),
        .i2c_rdata(i2c_rdata), .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_error(cfg_error),
        .id_mismatch(id_mismatch)
    );

    // Master model: log each request, answer LAT cycles later unless reset intervenes
    initial begin
        logic [2:0] ix;
        logic       aborted;
        i2c_done  = 1'b0;
        i2c_nack  = 1'b0;
        i2c_rdata = 8'h00;
        forever begin
            if (i2c_req === 1'b1 && rst === 1'b0) begin
                ix                = lut_index[2:0];
                req_idx[req_n]    = int'(lut_index);
                req_rd[req_n]     = i2c_rd;
                req_addr[req_n]   = i2c_addr;
                req_wdata[req_n]  = i2c_wdata;
                req_cyc[req_n]    = cyc;
                aborted           = 1'b0;
                for (int k = 0; k < LAT; k++) begin
                    @(negedge clk);
                    if (rst) aborted = 1'b1;
                end
                if (!aborted) begin
                    done_cyc[req_n] = cyc;
                    i2c_done        = 1'b1;
                    i2c_nack        = (req_idx[req_n] == nack_idx) && (nack_given < nack_end);
                    if (i2c_nack) nack_given = nack_given + 1;
                    i2c_rdata       = (id_bad && req_idx[req_n] == 1) ? 8'h00 : lut_tab[ix][7:0];
                    @(negedge clk);
                    i2c_done  = 1'b0;
                    i2c_nack  = 1'b0;
                    i2c_rdata = 8'h00;
                end
                req_n = req_n + 1;
            end else begin
                @(negedge clk);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_end(input string tag, input int maxc);
        int n;
        n = 0;
        while (!(cfg_done === 1'b1 || cfg_error === 1'b1) && n < maxc) begin
            @(negedge clk);
            n = n + 1;
        end
        check(tag, (n < maxc) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic pulse_restart(output int rcyc);
        @(negedge clk);
        rcyc        = cyc;
        cfg_restart = 1'b1;
        @(negedge clk);
        cfg_restart = 1'b0;
    endtask

    task automatic wait_req_idx(input string tag, input logic [7:0] idx);
        int n;
        n = 0;
        while (!(i2c_req === 1'b1 && lut_index == idx) && n < 500) begin
            @(negedge clk);
            n = n + 1;
        end
        check(tag, (n < 500) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        int base, rcyc, rel, cnt4;
        lut_tab[0] = 16'h0A77; lut_tab[1] = 16'h0B7F; lut_tab[2] = 16'h1280;
        lut_tab[3] = 16'h1101; lut_tab[4] = 16'h0C40; lut_tab[5] = 16'h0000;
        lut_tab[6] = 16'h0000; lut_tab[7] = 16'h0000;
        rst = 1'b1; cfg_restart = 1'b0; lut_size = 8'd5; id_bad = 1'b0;
        nack_idx = -1; nack_end = 0;
        repeat (3) @(negedge clk);
        check("rst_busy", cfg_busy, 1'b0);
        check("rst_req", i2c_req, 1'b0);
        check("rst_index", lut_index, 8'd0);
        check("rst_done", cfg_done, 1'b0);

        // T1 + T5: full sequence, ID reads match, settle delay after entry 2
        base = req_n;
        rst  = 1'b0;
        rel  = cyc;
        @(negedge clk);
        @(negedge clk);
        check("pwrup_busy", cfg_busy, 1'b1);
        check("pwrup_noreq", i2c_req, 1'b0);
        wait_end("t1_timeout", 2000);
        check("t1_done", cfg_done, 1'b1);
        check("t1_error", cfg_error, 1'b0);
        check("t1_mismatch", id_mismatch, 1'b0);
        check("t1_busy", cfg_busy, 1'b0);
        check("t1_count", req_n - base, 5);
        check("t1_pwrup_lat", req_cyc[base] - rel, 11);
        for (int i = 0; i < 5; i++) begin
            check("t1_idx", req_idx[base+i], i);
            check("t1_rd", req_rd[base+i], (i < 2) ? 1'b1 : 1'b0);
            check("t1_addr", req_addr[base+i], lut_tab[i][15:8]);
            check("t1_wdata", req_wdata[base+i], lut_tab[i][7:0]);
        end
        check("t5_plain_gap", req_cyc[base+2] - done_cyc[base+1], 3);
        check("t5_delay_gap", req_cyc[base+3] - done_cyc[base+2], 13);

        // T2: ID mismatch on entry 1, sequence still completes
        id_bad = 1'b1;
        base   = req_n;
        pulse_restart(rcyc);
        wait_end("t2_timeout", 2000);
        check("t2_mismatch", id_mismatch, 1'b1);
        check("t2_done", cfg_done, 1'b1);
        check("t2_count", req_n - base, 5);
        check("t2_restart_lat", req_cyc[base] - rcyc, 2);
        check("t2_first_idx", req_idx[base], 0);
        id_bad = 1'b0;

        // T3: two NACKs on entry 4 then ACK
        nack_idx = 4;
        nack_end = nack_given + 2;
        base     = req_n;
        pulse_restart(rcyc);
        wait_end("t3_timeout", 2000);
        cnt4 = 0;
        for (int i = base; i < req_n; i++) if (req_idx[i] == 4) cnt4 = cnt4 + 1;
        check("t3_idx4_reqs", cnt4, 3);
        check("t3_done", cfg_done, 1'b1);
        check("t3_error", cfg_error, 1'b0);
        check("t3_mismatch_cleared", id_mismatch, 1'b0);

        // T4: retries exhausted on entry 4
        nack_end = nack_given + 4;
        base     = req_n;
        pulse_restart(rcyc);
        wait_end("t4_timeout", 2000);
        check("t4_error", cfg_error, 1'b1);
        check("t4_done", cfg_done, 1'b0);
        check("t4_busy", cfg_busy, 1'b0);
        check("t4_index", lut_index, 8'd4);
        repeat (20) @(negedge clk);
        check("t4_total_reqs", req_n - base, 8);
        nack_idx = -1;

        // T6: restart while entry 3 is in flight
        base = req_n;
        pulse_restart(rcyc);
        wait_req_idx("t6_reach3", 8'd3);
        @(negedge clk);
        cfg_restart = 1'b1;
        @(negedge clk);
        cfg_restart = 1'b0;
        wait_end("t6_timeout", 2000);
        check("t6_count", req_n - base, 9);
        check("t6_after_idx", req_idx[base+4], 0);
        check("t6_after_gap", req_cyc[base+4] - done_cyc[base+3], 2);
        check("t6_done", cfg_done, 1'b1);

        // T7: reset mid-transaction
        pulse_restart(rcyc);
        wait_req_idx("t7_reach1", 8'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t7_busy", cfg_busy, 1'b0);
        check("t7_index", lut_index, 8'd0);
        check("t7_rd", i2c_rd, 1'b0);
        check("t7_addr", i2c_addr, 8'd0);
        repeat (6) @(negedge clk);
        base = req_n;
        rst  = 1'b0;
        rel  = cyc;
        wait_end("t7_timeout", 2000);
        check("t7_pwrup_lat", req_cyc[base] - rel, 11);
        check("t7_first_idx", req_idx[base], 0);
        check("t7_count", req_n - base, 5);

        // T8: empty LUT
        lut_size = 8'd0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        base = req_n;
        rst  = 1'b0;
        wait_end("t8_timeout", 200);
        check("t8_done", cfg_done, 1'b1);
        check("t8_busy", cfg_busy, 1'b0);
        check("t8_reqs", req_n - base, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
